// File: rtl/gsr_reset_sequencer_pkg.sv
// gsr_seq_pkg: state encodings, width helper and parameter legality for the GSR sequencer
package gsr_seq_pkg;
  localparam logic [1:0] HOLD    = 2'b00;
  localparam logic [1:0] STRETCH = 2'b01;
  localparam logic [1:0] RUN     = 2'b10;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
  function automatic bit params_ok(input int s, input int d, input int sc);
    return s >= 2 && d >= 1 && sc >= 1;
  endfunction
endpackage

// File: rtl/gsr_reset_sequencer_if.sv
// gsr_reset_sequencer_if: reset-cause inputs and GSR drive outputs of the sequencer
interface gsr_reset_sequencer_if;
  logic       ext_rstn;
  logic       pll_lock;
  logic       sw_rst;
  logic       gsrn;
  logic       rst_done;
  logic [1:0] state;
  modport master(output ext_rstn, pll_lock, sw_rst, input gsrn, rst_done, state);
  modport slave(input ext_rstn, pll_lock, sw_rst, output gsrn, rst_done, state);
endinterface

// File: rtl/gsr_reset_sequencer_filter.sv
// reset_sync_filter: multi-flop synchroniser with optional debouncer (DEBOUNCE_CYCLES=0 bypasses it)
module reset_sync_filter
  import gsr_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sync;
  always_ff @(posedge clk)
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  if (DEBOUNCE_CYCLES == 0) begin : g_raw
    assign o_q = r_sync[SYNC_STAGES-1];
  end else begin : g_deb
    localparam int CW = clog2(DEBOUNCE_CYCLES) + 1;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          w_diff;
    logic          w_flip;
    assign w_diff = r_sync[SYNC_STAGES-1] != r_level;
    assign w_flip = w_diff && r_cnt == CW'(DEBOUNCE_CYCLES - 1);
    // level resets low, i.e. an active-low input reads as asserted until proven stable high
    always_ff @(posedge clk)
      if (rst) begin
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_level <= w_flip ? ~r_level : r_level;
        r_cnt   <= (w_diff && !w_flip) ? r_cnt + CW'(1) : '0;
      end
    assign o_q = r_level;
  end
endmodule

// File: rtl/gsr_reset_sequencer.sv
// gsr_reset_sequencer: sequences GSRN release through HOLD/STRETCH/RUN with a minimum low time
module gsr_reset_sequencer
  import gsr_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 32
) (
  input logic                 clk,
  input logic                 rst,
  gsr_reset_sequencer_if.slave bus
);
  localparam int CW = clog2(STRETCH_CYCLES) + 1;
  if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES, STRETCH_CYCLES)) begin : g_bad
    $error("gsr_reset_sequencer: illegal parameter set");
  end
  logic          w_ext;
  logic          w_pll;
  logic          w_fault;
  logic          w_done;
  logic [1:0]    w_next;
  logic [CW-1:0] w_cnt;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_gsrn;
  logic          r_rst_done;
  reset_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ext (
    .clk(clk), .rst(rst), .i_d(bus.ext_rstn), .o_q(w_ext)
  );
  reset_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0)) u_pll (
    .clk(clk), .rst(rst), .i_d(bus.pll_lock), .o_q(w_pll)
  );
  // fault outranks SW_RST, which outranks stretch expiry
  always_comb begin
    w_fault = !w_ext || !w_pll;
    w_done  = r_cnt == CW'(STRETCH_CYCLES - 1);
    w_next  = w_fault ? HOLD :
              (r_state == HOLD) ? STRETCH :
              (r_state == RUN) ? (bus.sw_rst ? STRETCH : RUN) :
              (r_state == STRETCH) ? ((bus.sw_rst || !w_done) ? STRETCH : RUN) : HOLD;
    w_cnt   = (w_next == STRETCH && r_state == STRETCH && !bus.sw_rst) ? r_cnt + CW'(1) : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= HOLD;
      r_cnt      <= '0;
      r_gsrn     <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_gsrn     <= w_next == RUN;
      r_rst_done <= w_next == RUN;
    end
  assign bus.gsrn     = r_gsrn;
  assign bus.rst_done = r_rst_done;
  assign bus.state    = r_state;
endmodule
